// File: rtl/home_pkg.sv
// Shared definitions for the home-row slot logic: FSM states, slot limits and
// the default marker geometry that the sprite mapper also uses.
package home_pkg;

    typedef enum logic [1:0] {
        PLAY,
        CELEBRATE,
        CLEAR
    } home_state_t;

    localparam int MAX_SLOTS = 8;
    localparam int COORD_W   = 10;

    localparam int DEF_NUM_SLOTS  = 5;
    localparam int DEF_SLOT_X0    = 76;
    localparam int DEF_SLOT_PITCH = 116;
    localparam int DEF_SLOT_Y     = 20;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame counter that counts 0..TERMINAL while enabled, then wraps to 0.
// done is high while the count sits at TERMINAL.
module frame_timer #(
    parameter int WIDTH    = 8,
    parameter int TERMINAL = 1
) (
    input  logic frame_clk,
    input  logic Reset,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count;

    assign done = (count == TERM);

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= done ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/home_slot_tracker.sv
// Tracks which home slots along the top row are filled, runs the full-row
// celebration, then clears the row and advances the level counter.
module home_slot_tracker
    import home_pkg::*;
#(
    parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
    parameter int SLOT_X0      = DEF_SLOT_X0,
    parameter int SLOT_PITCH   = DEF_SLOT_PITCH,
    parameter int SLOT_Y       = DEF_SLOT_Y,
    parameter int CELEB_FRAMES = 120,
    parameter int BLINK_DIV    = 8,
    parameter int LEVEL_W      = 4
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic                 arrive,
    input  logic [2:0]           arrive_slot,
    input  logic                 restart,
    output logic [NUM_SLOTS-1:0] occupied,
    output logic [COORD_W-1:0]   slot_x [NUM_SLOTS],
    output logic [COORD_W-1:0]   slot_y [NUM_SLOTS],
    output logic                 accept,
    output logic                 reject,
    output logic [3:0]           fill_count,
    output logic                 celebrating,
    output logic                 blink,
    output logic                 level_done,
    output logic [LEVEL_W-1:0]   level
);

    localparam int CELEB_W = cnt_width(CELEB_FRAMES);
    localparam int BLINK_W = cnt_width(BLINK_DIV);

    home_state_t state, state_n;

    logic [NUM_SLOTS-1:0] occupied_n;
    logic [3:0]           fill_n;
    logic                 accept_n, reject_n, level_done_n;
    logic                 celebrating_n, blink_n;
    logic [LEVEL_W-1:0]   level_n;

    logic celeb_clr, celeb_en, celeb_done;
    logic blink_clr, blink_en, blink_done;

    logic [MAX_SLOTS-1:0] occ_pad, slot_bit;
    logic                 slot_valid, slot_taken;

    // Marker geometry is fixed wiring, so it is visible even while in reset.
    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_marker
        assign slot_x[i] = COORD_W'(SLOT_X0 + i * SLOT_PITCH);
        assign slot_y[i] = COORD_W'(SLOT_Y);
    end

    // Pad the mask to the full 3-bit index range so any arrive_slot is safe to use.
    assign occ_pad    = MAX_SLOTS'(occupied);
    assign slot_bit   = MAX_SLOTS'(1) << arrive_slot;
    assign slot_valid = (4'(arrive_slot) < 4'(NUM_SLOTS));
    assign slot_taken = occ_pad[arrive_slot];

    frame_timer #(
        .WIDTH   (CELEB_W),
        .TERMINAL(CELEB_FRAMES - 1)
    ) u_celeb_timer (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .clear    (celeb_clr),
        .enable   (celeb_en),
        .done     (celeb_done)
    );

    frame_timer #(
        .WIDTH   (BLINK_W),
        .TERMINAL(BLINK_DIV - 1)
    ) u_blink_timer (
        .frame_clk(frame_clk),
        .Reset    (Reset),
        .clear    (blink_clr),
        .enable   (blink_en),
        .done     (blink_done)
    );

    // State and every published output are registered together so the
    // row-clear effects land on the same edge that enters CLEAR.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state       <= PLAY;
            occupied    <= '0;
            fill_count  <= '0;
            accept      <= 1'b0;
            reject      <= 1'b0;
            celebrating <= 1'b0;
            blink       <= 1'b0;
            level_done  <= 1'b0;
            level       <= '0;
        end else begin
            state       <= state_n;
            occupied    <= occupied_n;
            fill_count  <= fill_n;
            accept      <= accept_n;
            reject      <= reject_n;
            celebrating <= celebrating_n;
            blink       <= blink_n;
            level_done  <= level_done_n;
            level       <= level_n;
        end
    end

    always_comb begin
        state_n       = state;
        occupied_n    = occupied;
        fill_n        = fill_count;
        accept_n      = 1'b0;
        reject_n      = 1'b0;
        level_done_n  = 1'b0;
        celebrating_n = celebrating;
        blink_n       = blink;
        level_n       = level;
        celeb_clr     = 1'b0;
        celeb_en      = 1'b0;
        blink_clr     = 1'b0;
        blink_en      = 1'b0;

        if (restart) begin
            state_n       = PLAY;
            occupied_n    = '0;
            fill_n        = '0;
            celebrating_n = 1'b0;
            blink_n       = 1'b0;
            level_n       = '0;
            celeb_clr     = 1'b0 | 1'b1;
            blink_clr     = 1'b1;
        end else begin
            case (state)
                PLAY: begin
                    if (arrive) begin
                        if (!slot_valid || slot_taken) begin
                            reject_n = 1'b1;
                        end else begin
                            occupied_n = occupied | slot_bit[NUM_SLOTS-1:0];
                            fill_n     = fill_count + 4'd1;
                            accept_n   = 1'b1;
                            // The final accept launches the celebration on the same edge.
                            if (fill_n == 4'(NUM_SLOTS)) begin
                                state_n       = CELEBRATE;
                                celebrating_n = 1'b1;
                                blink_n       = 1'b1;
                                celeb_clr     = 1'b1;
                                blink_clr     = 1'b1;
                            end
                        end
                    end
                end

                CELEBRATE: begin
                    celeb_en = 1'b1;
                    blink_en = 1'b1;
                    if (blink_done) begin
                        blink_n = ~blink;
                    end
                    if (celeb_done) begin
                        state_n       = CLEAR;
                        celebrating_n = 1'b0;
                        blink_n       = 1'b0;
                        occupied_n    = '0;
                        fill_n        = '0;
                        level_done_n  = 1'b1;
                        level_n       = level + 1'b1;
                    end
                end

                CLEAR: begin
                    state_n = PLAY;
                end

                default: begin
                    state_n = PLAY;
                end
            endcase
        end
    end

endmodule

// File: doc/home_slot_tracker.md
# home_slot_tracker

Parametrised tracker for the frog home slots along the top row of the playfield. It latches slot occupancy when the frog lands in a home slot and rejects landings on occupied or invalid slots. It publishes per-slot marker positions, a blink signal and the fill count to the sprite/colour mapper. When every slot is filled it runs a timed celebration, then clears the row and advances the level counter for the game controller.

## Interface

Parameters:

- NUM_SLOTS, 5, number of home slots (1..8)
- SLOT_X0, 76, x pixel of slot 0 marker
- SLOT_PITCH, 116, x spacing between adjacent slots
- SLOT_Y, 20, y pixel of every marker
- CELEB_FRAMES, 120, frames spent in celebration
- BLINK_DIV, 8, frames per blink half-period
- LEVEL_W, 4, level counter width

Ports:

- frame_clk, input, 1, frame-rate clock (one edge per video frame)
- Reset, input, 1, asynchronous active-high reset
- arrive, input, 1, one-frame pulse: frog reached the top row
- arrive_slot, input, 3, slot index of the arrival
- restart, input, 1, synchronous game restart (clears slots and level)
- occupied, output, NUM_SLOTS, occupancy mask, bit i = slot i filled
- slot_x[NUM_SLOTS], output, 10 each, marker x (constant SLOT_X0 + i*SLOT_PITCH)
- slot_y[NUM_SLOTS], output, 10 each, marker y (constant SLOT_Y)
- accept, output, 1, one-frame pulse: arrival latched
- reject, output, 1, one-frame pulse: arrival refused (frog dies)
- fill_count, output, 4, number of occupied slots
- celebrating, output, 1, high while in CELEBRATE
- blink, output, 1, marker blink phase, valid while celebrating
- level_done, output, 1, one-frame pulse when the row clears
- level, output, LEVEL_W, completed-level counter

## Operation

- FSM states: PLAY, CELEBRATE, CLEAR.
- Reset values: state PLAY, occupied 0, fill_count 0, accept/reject/level_done 0, celebrating 0, blink 0, level 0, timers 0.

PLAY, when arrive=1:
- If arrive_slot ≥ NUM_SLOTS, the frame is a reject.
- Else if occupied[arrive_slot]=1, the frame is a reject.
- Otherwise set the occupied bit, increment fill_count and pulse accept.
- If this accept makes fill_count equal to NUM_SLOTS, the next state is CELEBRATE and the frame timer loads 0.

CELEBRATE:
- arrive is ignored: no accept, no reject.
- The frame timer increments each frame.
- blink toggles every BLINK_DIV frames, starting at 1 on entry.
- On the frame where the timer reaches CELEB_FRAMES-1, the next state is CLEAR.

CLEAR (one frame):
- occupied and fill_count go to 0 and blink goes to 0.
- level_done pulses.
- level increments and wraps modulo 2^LEVEL_W.
- Next state is PLAY.

Other rules:
- restart, in any state, behaves like reset except it is synchronous. It takes priority over arrive and over the FSM.
- slot_x/slot_y are combinational constants, available even during reset.

## Timing

- All outputs except slot_x/slot_y are registered.
- accept, reject and the occupied update appear on the frame edge after the arrive frame (1-frame latency).
- The celebrating rise coincides with the accept of the final slot.
- Celebration lasts exactly CELEB_FRAMES frames. level_done follows the last celebrating frame by one frame, and occupied is 0 in that same frame.
- Arrivals are accepted again starting the frame after level_done.
- arrive held high for several frames counts as one arrival per frame. The second and later frames reject once the slot is occupied.
- Reset asserted mid-celebration returns immediately to the reset values. level is not incremented.
- If restart and arrive occur in the same frame, restart wins and no accept or reject is issued.

## Structure

- Shared package home_pkg holds:
  - the FSM state enum (PLAY, CELEBRATE, CLEAR)
  - the constants MAX_SLOTS=8 and COORD_W=10
  - the default slot geometry constants, reused by the sprite mapper
- One natural sub-module, frame_timer: a counter with clear, enable and terminal-count flag. It is instantiated once for the celebration and once for the blink divider.

## Test plan

- **Reset:** after Reset, check occupied=0, fill_count=0, level=0. slot_x must read 76, 192, 308, 424, 540 and slot_y must read 20.
- **Accept and reject:** arrive with slot 2 gives accept=1 next frame and occupied=00100. A second arrive with slot 2 gives reject=1 and no mask change. arrive with slot 6 gives reject=1.
- **Full row:** fill slots 0,1,2,3,4 on successive frames. celebrating rises with the fifth accept. An arrive during celebration produces neither accept nor reject. blink toggles every 8 frames. After 120 frames level_done=1, occupied=0, level=1.
- **Level wrap:** complete 16 rows; level wraps from 15 to 0.
- **Reset mid-celebration:** assert Reset at frame 50 of the celebration. Outputs return to reset values, level_done never pulses and level stays 0.
- **Restart collision:** restart together with arrive on slot 1 gives occupied=0 and no accept; with NUM_SLOTS=3 the full row completes after 3 accepts.
